// File: rtl/sp_sram_arbiter.sv
// Two-requester round-robin arbiter and registered command sequencer for the
// AES single-port SRAM. Returns tagged one-cycle read-valid pulses to the
// requester that owns each read.
module sp_sram_arbiter #(
    parameter int unsigned AW = 7,
    parameter int unsigned DW = 128
) (
    input  logic          iClk,
    input  logic          iRst,
    // requester A: key-expansion / round-key writer
    input  logic          iReqA,
    input  logic          iWrnA,
    input  logic [3:0]    iWdSelA,
    input  logic [AW-1:0] iAddrA,
    input  logic [DW-1:0] iWrDtA,
    output logic          oGntA,
    output logic          oRdVldA,
    output logic [DW-1:0] oRdDtA,
    // requester B: state-buffer read/write path
    input  logic          iReqB,
    input  logic          iWrnB,
    input  logic [3:0]    iWdSelB,
    input  logic [AW-1:0] iAddrB,
    input  logic [DW-1:0] iWrDtB,
    output logic          oGntB,
    output logic          oRdVldB,
    output logic [DW-1:0] oRdDtB,
    // SRAM command and read data
    output logic          oSramCsn,
    output logic          oSramWrn,
    output logic [3:0]    oSramWdSel,
    output logic [AW-1:0] oSramAddr,
    output logic [DW-1:0] oSramWrDt,
    input  logic [DW-1:0] iSramRdDt
);

    localparam int unsigned NL = 4;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

    // round-robin history: owner of the most recent grant
    owner_e           last_q, last_d;

    // registered SRAM command
    logic             csn_q, csn_d;
    logic             wrn_q, wrn_d;
    logic [NL-1:0]    wdsel_q, wdsel_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wrdt_q, wrdt_d;

    // read-return tag pipeline; stage 2 is kept decoded per requester
    logic             tag1_vld_q, tag1_vld_d;
    owner_e           tag1_own_q, tag1_own_d;
    logic             rd_vld_a_q, rd_vld_a_d;
    logic             rd_vld_b_q, rd_vld_b_d;

    logic             gnt_a_c, gnt_b_c;

    // Arbitration: a lone request wins; a tie goes to whoever did not win last.
    always_comb begin
        gnt_a_c = 1'b0;
        gnt_b_c = 1'b0;
        if (!iRst) begin
            if (iReqA && iReqB) begin
                if (last_q == OWN_B) begin
                    gnt_a_c = 1'b1;
                end else begin
                    gnt_b_c = 1'b1;
                end
            end else begin
                gnt_a_c = iReqA;
                gnt_b_c = iReqB;
            end
        end
    end

    // Next command, round-robin history and read tags from this cycle's grant.
    always_comb begin
        last_d     = last_q;
        csn_d      = 1'b1;
        wrn_d      = 1'b1;
        wdsel_d    = {NL{1'b1}};
        addr_d     = addr_q;
        wrdt_d     = wrdt_q;
        tag1_vld_d = 1'b0;
        tag1_own_d = tag1_own_q;
        rd_vld_a_d = tag1_vld_q && (tag1_own_q == OWN_A);
        rd_vld_b_d = tag1_vld_q && (tag1_own_q == OWN_B);

        if (gnt_a_c) begin
            last_d     = OWN_A;
            csn_d      = 1'b0;
            wrn_d      = iWrnA;
            wdsel_d    = iWrnA ? {NL{1'b1}} : iWdSelA;
            addr_d     = iAddrA;
            wrdt_d     = iWrDtA;
            tag1_vld_d = iWrnA;
            tag1_own_d = OWN_A;
        end else if (gnt_b_c) begin
            last_d     = OWN_B;
            csn_d      = 1'b0;
            wrn_d      = iWrnB;
            wdsel_d    = iWrnB ? {NL{1'b1}} : iWdSelB;
            addr_d     = iAddrB;
            wrdt_d     = iWrDtB;
            tag1_vld_d = iWrnB;
            tag1_own_d = OWN_B;
        end
    end

    // State registers with synchronous reset; reset also drops in-flight reads.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            last_q     <= OWN_B;
            csn_q      <= 1'b1;
            wrn_q      <= 1'b1;
            wdsel_q    <= {NL{1'b1}};
            addr_q     <= '0;
            wrdt_q     <= '0;
            tag1_vld_q <= 1'b0;
            tag1_own_q <= OWN_A;
            rd_vld_a_q <= 1'b0;
            rd_vld_b_q <= 1'b0;
        end else begin
            last_q     <= last_d;
            csn_q      <= csn_d;
            wrn_q      <= wrn_d;
            wdsel_q    <= wdsel_d;
            addr_q     <= addr_d;
            wrdt_q     <= wrdt_d;
            tag1_vld_q <= tag1_vld_d;
            tag1_own_q <= tag1_own_d;
            rd_vld_a_q <= rd_vld_a_d;
            rd_vld_b_q <= rd_vld_b_d;
        end
    end

    assign oGntA      = gnt_a_c;
    assign oGntB      = gnt_b_c;
    assign oRdVldA    = rd_vld_a_q;
    assign oRdVldB    = rd_vld_b_q;
    assign oRdDtA     = iSramRdDt;
    assign oRdDtB     = iSramRdDt;
    assign oSramCsn   = csn_q;
    assign oSramWrn   = wrn_q;
    assign oSramWdSel = wdsel_q;
    assign oSramAddr  = addr_q;
    assign oSramWrDt  = wrdt_q;

endmodule

// File: tb/tb_sp_sram_arbiter.sv
// Self-checking bench for sp_sram_arbiter: directed scenarios followed by
// randomized traffic, checked against a transaction-level reference model.
module tb_sp_sram_arbiter;

    localparam int unsigned AW = 7;
    localparam int unsigned DW = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_a, wrn_a, req_b, wrn_b;
    logic [3:0]    sel_a, sel_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] dt_a, dt_b;
    logic          gnt_a, gnt_b, rd_vld_a, rd_vld_b;
    logic [DW-1:0] rd_dt_a, rd_dt_b;
    logic          sram_csn, sram_wrn;
    logic [3:0]    sram_wdsel;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wrdt;
    logic [DW-1:0] sram_rd;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sp_sram_arbiter #(.AW(AW), .DW(DW)) dut (
        .iClk(clk), .iRst(rst),
        .iReqA(req_a), .iWrnA(wrn_a), .iWdSelA(sel_a), .iAddrA(addr_a), .iWrDtA(dt_a),
        .oGntA(gnt_a), .oRdVldA(rd_vld_a), .oRdDtA(rd_dt_a),
        .iReqB(req_b), .iWrnB(wrn_b), .iWdSelB(sel_b), .iAddrB(addr_b), .iWrDtB(dt_b),
        .oGntB(gnt_b), .oRdVldB(rd_vld_b), .oRdDtB(rd_dt_b),
        .oSramCsn(sram_csn), .oSramWrn(sram_wrn), .oSramWdSel(sram_wdsel),
        .oSramAddr(sram_addr), .oSramWrDt(sram_wrdt), .iSramRdDt(sram_rd)
    );

    // Behavioural single-port SRAM: samples command on the edge, registered read.
    logic [DW-1:0] sram_mem [128];
    always @(posedge clk) begin
        if (!sram_csn) begin
            if (!sram_wrn) begin
                for (int l = 0; l < 4; l++)
                    if (!sram_wdsel[l]) sram_mem[sram_addr][32*l +: 32] <= sram_wrdt[32*l +: 32];
            end else begin
                sram_rd <= sram_mem[sram_addr];
            end
        end
    end

    // Reference model: memory updated in grant order, reads due two cycles after grant.
    typedef struct {
        int            due;
        bit            own_b;
        logic [DW-1:0] data;
    } rd_exp_t;

    logic [DW-1:0] ref_mem [128];
    rd_exp_t       pend[$];
    int            cyc = 0;
    bit            last_b = 1'b1;
    bit            prev_gnt_a = 1'b0;
    bit            prev_gnt_b = 1'b0;
    logic          exp_csn, exp_wrn;
    logic [3:0]    exp_sel;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wrdt;
    logic [DW-1:0] last_rd_a, last_rd_b;
    int            vld_a_cnt = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic set_a(input logic r, input logic w, input logic [3:0] s,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_a = r; wrn_a = w; sel_a = s; addr_a = a; dt_a = d;
    endtask

    task automatic set_b(input logic r, input logic w, input logic [3:0] s,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_b = r; wrn_b = w; sel_b = s; addr_b = a; dt_b = d;
    endtask

    // Hold a pending request until granted (rarely withdrawing it), else issue a fresh one.
    task automatic gen_req(input bit granted, inout logic r, inout logic w, inout logic [3:0] s,
                           inout logic [AW-1:0] a, inout logic [DW-1:0] d);
        if (r && !granted) begin
            if ($urandom_range(15) == 0) r = 1'b0;
        end else begin
            r = ($urandom_range(9) < 7);
            w = 1'($urandom_range(1));
            s = ($urandom_range(3) == 0) ? 4'hF : 4'($urandom);
            a = AW'($urandom_range(7));
            d = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    // One clock cycle: check grants mid-cycle, advance the model, check registered outputs.
    task automatic step();
        logic          ea, eb, xa, xb, w_wrn;
        logic [3:0]    w_sel;
        logic [AW-1:0] w_addr;
        logic [DW-1:0] w_dt, da, db;
        rd_exp_t       e;
        #4;
        ea = 1'b0;
        eb = 1'b0;
        if (!rst) begin
            if (req_a && req_b) begin
                ea = last_b;
                eb = !last_b;
            end else begin
                ea = req_a;
                eb = req_b;
            end
        end
        check("gnt_a", DW'(gnt_a), DW'(ea));
        check("gnt_b", DW'(gnt_b), DW'(eb));
        prev_gnt_a = ea;
        prev_gnt_b = eb;
        if (rst) begin
            last_b   = 1'b1;
            exp_csn  = 1'b1;
            exp_wrn  = 1'b1;
            exp_sel  = 4'hF;
            exp_addr = '0;
            exp_wrdt = '0;
            pend.delete();
        end else if (ea || eb) begin
            w_wrn  = ea ? wrn_a  : wrn_b;
            w_sel  = ea ? sel_a  : sel_b;
            w_addr = ea ? addr_a : addr_b;
            w_dt   = ea ? dt_a   : dt_b;
            last_b = eb;
            if (!w_wrn) begin
                for (int l = 0; l < 4; l++)
                    if (!w_sel[l]) ref_mem[w_addr][32*l +: 32] = w_dt[32*l +: 32];
            end else begin
                e.due   = cyc + 2;
                e.own_b = eb;
                e.data  = ref_mem[w_addr];
                pend.push_back(e);
            end
            exp_csn  = 1'b0;
            exp_wrn  = w_wrn;
            exp_sel  = w_wrn ? 4'hF : w_sel;
            exp_addr = w_addr;
            exp_wrdt = w_dt;
        end else begin
            exp_csn = 1'b1;
            exp_wrn = 1'b1;
            exp_sel = 4'hF;
        end

        @(posedge clk);
        #1;
        cyc++;
        check("sram_csn",   DW'(sram_csn),   DW'(exp_csn));
        check("sram_wrn",   DW'(sram_wrn),   DW'(exp_wrn));
        check("sram_wdsel", DW'(sram_wdsel), DW'(exp_sel));
        check("sram_addr",  DW'(sram_addr),  DW'(exp_addr));
        check("sram_wrdt",  sram_wrdt,       exp_wrdt);
        xa = 1'b0; xb = 1'b0; da = '0; db = '0;
        foreach (pend[i]) begin
            if (pend[i].due == cyc) begin
                if (pend[i].own_b) begin xb = 1'b1; db = pend[i].data; end
                else               begin xa = 1'b1; da = pend[i].data; end
            end
        end
        while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
        check("rd_vld_a", DW'(rd_vld_a), DW'(xa));
        check("rd_vld_b", DW'(rd_vld_b), DW'(xb));
        if (xa) check("rd_dt_a", rd_dt_a, da);
        if (xb) check("rd_dt_b", rd_dt_b, db);
        if (rd_vld_a) begin last_rd_a = rd_dt_a; vld_a_cnt++; end
        if (rd_vld_b) last_rd_b = rd_dt_b;
    endtask

    task automatic idle(input int n);
        set_a(1'b0, 1'b1, 4'hF, '0, '0);
        set_b(1'b0, 1'b1, 4'hF, '0, '0);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int cnt0;
        for (int i = 0; i < 128; i++) begin
            sram_mem[i] = '0;
            ref_mem[i]  = '0;
        end
        sram_rd   = '0;
        last_rd_a = '0;
        last_rd_b = '0;
        rst = 1'b1;
        set_a(1'b1, 1'b0, 4'h0, 7'h05, {4{32'h11111111}});
        set_b(1'b0, 1'b1, 4'hF, '0, '0);
        @(posedge clk);
        #1;

        // reset with A requesting, then A wins on the first cycle out of reset
        step();
        step();
        rst = 1'b0;
        step();

        // A reads back its write two cycles after the read grant
        set_a(1'b1, 1'b1, 4'hF, 7'h05, '0);
        step();
        idle(3);
        check("a_readback", last_rd_a, {4{32'h11111111}});

        // lane mask: full write then lane-0-only write of zero
        set_a(1'b1, 1'b0, 4'h0, 7'h10, {4{32'hFFFFFFFF}});
        step();
        set_a(1'b0, 1'b1, 4'hF, '0, '0);
        set_b(1'b1, 1'b0, 4'b1110, 7'h10, '0);
        step();
        set_b(1'b1, 1'b1, 4'hF, 7'h10, '0);
        step();
        idle(3);
        check("lane_mask", last_rd_b, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_00000000);

        // both requesting continuously: grants alternate, SRAM busy every cycle
        set_a(1'b1, 1'b1, 4'hF, 7'h01, '0);
        set_b(1'b1, 1'b1, 4'hF, 7'h02, '0);
        for (int i = 0; i < 6; i++) step();
        idle(3);

        // read-then-write and write-then-read ordering on one address
        set_a(1'b1, 1'b0, 4'h0, 7'h20, {4{32'hAAAAAAAA}});
        step();
        set_a(1'b1, 1'b1, 4'hF, 7'h20, '0);
        step();
        set_a(1'b0, 1'b1, 4'hF, '0, '0);
        set_b(1'b1, 1'b0, 4'h0, 7'h20, {4{32'hBBBBBBBB}});
        step();
        set_b(1'b1, 1'b1, 4'hF, 7'h20, '0);
        step();
        idle(3);
        check("rd_before_wr", last_rd_a, {4{32'hAAAAAAAA}});
        check("wr_before_rd", last_rd_b, {4{32'hBBBBBBBB}});

        // reset right after a read grant drops the read and restores the command pins
        set_a(1'b1, 1'b1, 4'hF, 7'h05, '0);
        step();
        cnt0 = vld_a_cnt;
        set_a(1'b0, 1'b1, 4'hF, '0, '0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        step();
        step();
        check("rst_flush", DW'(vld_a_cnt - cnt0), '0);

        // randomized traffic with occasional resets on a small address window
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(99) == 0);
            gen_req(prev_gnt_a, req_a, wrn_a, sel_a, addr_a, dt_a);
            gen_req(prev_gnt_b, req_b, wrn_b, sel_b, addr_b, dt_b);
            step();
        end
        rst = 1'b0;
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sp_sram_arbiter.md
Name: sp_sram_arbiter

Overview:
Two-requester round-robin arbiter and command sequencer for the 128x128 single-port SRAM in the AES datapath. Requester A is the key-expansion/round-key writer; requester B is the state-buffer read/write path. The block issues at most one SRAM command per cycle and drives the SRAM command pins from registers. It returns tagged, 1-cycle read-valid pulses to whichever requester owns each read.

Parameters:
AW, 7, SRAM address width (128 words)
DW, 128, SRAM data width (4 x 32-bit lanes)

Ports:
iClk  in  1  clock, rising edge
iRst  in  1  reset, synchronous, active-high
iReqA  in  1  requester A command pending; held with fields until oGntA
iWrnA  in  1  A: 0 = write, 1 = read
iWdSelA  in  4  A: write lane select, active-low per 32-bit lane
iAddrA  in  AW  A: word address
iWrDtA  in  DW  A: write data
oGntA  out  1  A command accepted this cycle (combinational)
oRdVldA  out  1  A read data valid (1-cycle pulse)
oRdDtA  out  DW  A read data (= iSramRdDt)
iReqB, iWrnB, iWdSelB, iAddrB, iWrDtB, oGntB, oRdVldB, oRdDtB: same as A, for requester B
oSramCsn  out  1  SRAM chip select, active-low (registered)
oSramWrn  out  1  SRAM 0 = write, 1 = read (registered)
oSramWdSel  out  4  SRAM lane select, active-low (registered)
oSramAddr  out  AW  SRAM address (registered)
oSramWrDt  out  DW  SRAM write data (registered)
iSramRdDt  in  DW  SRAM registered read data

Behaviour:
- Clock/reset: one clock iClk; reset iRst is synchronous and active-high.
- Arbitration (combinational, cycle N):
  - Only one request -> grant it.
  - Both requesting -> grant the one not granted last (rLast).
  - At most one of oGntA/oGntB is high. Neither is high without its request.
- rLast updates only on a grant cycle. Reset value = B, so A wins the first tie.
- Handshake: the requester holds iReq and all fields stable until it sees oGnt high. The grant cycle is the transfer.
  - Back-to-back: iReq stays high with new fields on the cycle after the grant.
  - No double issue: grant is evaluated on the current fields only.
- Command register (edge ending N):
  - On a grant: oSramCsn=0, oSramWrn/oSramAddr/oSramWrDt = winner's fields.
  - oSramWdSel = winner's iWdSel for a write, 4'hF for a read.
  - No grant: oSramCsn=1, oSramWrn=1, oSramWdSel=4'hF; oSramAddr/oSramWrDt hold their previous values.
- SRAM samples the command at the edge ending N+1. Read data appears on iSramRdDt in N+2.
- Read return pipeline: 2-stage tag {vld, owner}, loaded on a read grant.
  - Stage-2 valid with owner A -> oRdVldA=1 in N+2; owner B -> oRdVldB=1.
  - Grant-to-data read latency is fixed at 2 cycles.
  - Throughput: 1 command/cycle. Reads and writes interleave freely.
- oRdDtA = oRdDtB = iSramRdDt, qualified only by the matching oRdVld.
- Write with iWdSel=4'hF: granted and consumes the slot; the SRAM modifies nothing.
- Read-then-write to the same address in consecutive grants: the read returns the pre-write data.
- Write-then-read to the same address in consecutive grants: the read returns the new data.
- Reset values (any time, including mid-operation):
  - oSramCsn=1, oSramWrn=1, oSramWdSel=4'hF, oSramAddr=0, oSramWrDt=0.
  - Tag pipeline cleared; in-flight reads produce no oRdVld.
  - rLast=B.
  - No grants while iRst=1.
- Requests dropped before a grant are legal and simply never issue.

Test Plan:
- Reset with iReqA=1, iRst=1 -> oGntA=0, oSramCsn=1, oSramWdSel=F; after release, oGntA=1 on the first cycle.
- A writes addr 0x05 data 0x1111..(128b), iWdSelA=0; then A reads 0x05 -> oRdVldA pulses exactly 2 cycles after the read grant with 0x1111.., and oRdVldB stays 0.
- A and B both requesting continuously for 6 cycles -> grants alternate A,B,A,B,A,B and oSramCsn is 0 every cycle.
- Lane mask: write 0xFFFF.. to 0x10 with mask 0, then 0x0 with iWdSelB=4'b1110 -> read 0x10 returns 0xFFFFFFFF_FFFFFFFF_FFFFFFFF_00000000.
- A reads 0x20 (holds 0xAA..) granted, B writes 0xBB.. to 0x20 on the next grant -> A's data = 0xAA..; a subsequent B read returns 0xBB..
- A read granted, iRst asserted the next cycle for 1 cycle -> no oRdVldA, and all SRAM outputs are at reset values.
